// File: rtl/code_lock_if.sv
// ---------------------------------------------------------------------------
// code_lock_if
// Bundles the keypad-side controls and the lock status outputs of
// code_lock_fsm into one interface.
//
// Signals:
//   key_valid  - single-cycle strobe; key_digit is valid
//   key_digit  - digit value, DIGIT_W bits
//   clear      - abort the current entry
//   relock     - end the unlock window early
//   prog_req   - request programming mode (only honoured while unlocked)
//   unlocked   - actuator enable
//   locked_out - lockout active
//   prog_mode  - programming in progress
//   fail_cnt   - consecutive failures, $clog2(MAX_FAIL+1) bits
//   digit_cnt  - digits captured in current entry, $clog2(CODE_LEN+1) bits
//   state      - 00 IDLE, 01 UNLOCK, 10 LOCKOUT, 11 PROG
//
// Modports:
//   master - keypad/actuator side: drives controls, observes status
//   slave  - the lock controller itself
// ---------------------------------------------------------------------------
interface code_lock_if #(
    parameter int DIGIT_W  = 4,
    parameter int CODE_LEN = 4,
    parameter int MAX_FAIL = 3
);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               clear;
    logic               relock;
    logic               prog_req;
    logic               unlocked;
    logic               locked_out;
    logic               prog_mode;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [CNT_W-1:0]   digit_cnt;
    logic [1:0]         state;

    // Keypad / supervisor side
    modport master (
        output key_valid, key_digit, clear, relock, prog_req,
        input  unlocked, locked_out, prog_mode, fail_cnt, digit_cnt, state
    );

    // Lock controller side
    modport slave (
        input  key_valid, key_digit, clear, relock, prog_req,
        output unlocked, locked_out, prog_mode, fail_cnt, digit_cnt, state
    );
endinterface

// File: rtl/code_lock_fsm.sv
// ---------------------------------------------------------------------------
// code_lock_fsm
// Keypad lock controller. A CODE_LEN-digit code is entered one digit per
// key strobe. A correct code opens the lock for UNLOCK_CYC cycles, MAX_FAIL
// consecutive wrong codes force a LOCKOUT_CYC-cycle lockout, and while
// unlocked the code can be reprogrammed. The first-entered digit is the most
// significant digit of the code register.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - code_lock_if.slave: key_valid, key_digit, clear, relock,
//          prog_req in; unlocked, locked_out, prog_mode, fail_cnt,
//          digit_cnt, state out (all registered or decoded from state)
// ---------------------------------------------------------------------------
module code_lock_fsm #(
    parameter int                             DIGIT_W      = 4,
    parameter int                             CODE_LEN     = 4,
    parameter int                             MAX_FAIL     = 3,
    parameter int                             LOCKOUT_CYC  = 16,
    parameter int                             UNLOCK_CYC   = 8,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE = 16'h1234
) (
    input logic          clk,
    input logic          rst,
    code_lock_if.slave   bus
);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int TMAX    = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_UNLOCK  = 2'b01,
        ST_LOCKOUT = 2'b10,
        ST_PROG    = 2'b11
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code_reg;
    logic [CODE_W-1:0]   shadow;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]    digit_cnt;
    logic [TIMER_W-1:0]  timer;
    logic                mismatch;

    logic [DIGIT_W-1:0]  exp_digit;
    logic                digit_miss;
    logic                last_digit;
    logic [CODE_W-1:0]   next_shadow;

    // Per-strobe helpers: the stored digit the current key is compared
    // against, whether this strobe completes an entry, and the shadow
    // register with the incoming digit shifted in at the bottom (so the
    // first digit ends up most significant after CODE_LEN strobes).
    always_comb begin
        exp_digit   = code_reg[DIGIT_W*(CODE_LEN-1-int'(digit_cnt)) +: DIGIT_W];
        digit_miss  = (bus.key_digit != exp_digit);
        last_digit  = (digit_cnt == CNT_W'(CODE_LEN - 1));
        next_shadow = CODE_W'({shadow, bus.key_digit});
    end

    // Main controller. A single timer serves both the unlock window and
    // the lockout: it is loaded with length-1 on entry and the state is
    // left on the edge where it reads zero, giving exactly length cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            code_reg  <= DEFAULT_CODE;
            shadow    <= '0;
            fail_cnt  <= '0;
            digit_cnt <= '0;
            timer     <= '0;
            mismatch  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                    end else if (bus.key_valid) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                            if (!mismatch && !digit_miss) begin
                                state    <= ST_UNLOCK;
                                fail_cnt <= '0;
                                timer    <= TIMER_W'(UNLOCK_CYC - 1);
                            end else if (fail_cnt >= FAIL_W'(MAX_FAIL - 1)) begin
                                state    <= ST_LOCKOUT;
                                fail_cnt <= FAIL_W'(MAX_FAIL);
                                timer    <= TIMER_W'(LOCKOUT_CYC - 1);
                            end else begin
                                fail_cnt <= fail_cnt + FAIL_W'(1);
                            end
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                            mismatch  <= mismatch | digit_miss;
                        end
                    end
                end

                ST_UNLOCK: begin
                    if (bus.relock) begin
                        state <= ST_IDLE;
                    end else if (bus.prog_req) begin
                        state     <= ST_PROG;
                        digit_cnt <= '0;
                        shadow    <= '0;
                    end else if (timer == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= ST_IDLE;
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                ST_PROG: begin
                    if (bus.clear) begin
                        state     <= ST_IDLE;
                        digit_cnt <= '0;
                    end else if (bus.key_valid) begin
                        shadow <= next_shadow;
                        if (last_digit) begin
                            code_reg  <= next_shadow;
                            state     <= ST_IDLE;
                            digit_cnt <= '0;
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    digit_cnt <= '0;
                    mismatch  <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of registered state
    assign bus.state      = state;
    assign bus.unlocked   = (state == ST_UNLOCK);
    assign bus.locked_out = (state == ST_LOCKOUT);
    assign bus.prog_mode  = (state == ST_PROG);
    assign bus.fail_cnt   = fail_cnt;
    assign bus.digit_cnt  = digit_cnt;
endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised keypad lock controller; successor to the 2-button sequence lock.
- Accepts a programmable multi-digit code entered one digit per key strobe.
- Enforces lockout after repeated failures and a timed unlock window; the code can be reprogrammed while unlocked.
- Sits between the keypad debouncer/encoder and the actuator driver.

Parameters:
- DIGIT_W, 4: width of one key digit.
- CODE_LEN, 4: digits per code (≥1).
- MAX_FAIL, 3: consecutive wrong codes before lockout (≥1).
- LOCKOUT_CYC, 16: clock cycles spent in lockout (≥1).
- UNLOCK_CYC, 8: clock cycles the unlock output is held (≥1).
- DEFAULT_CODE, 16'h1234: reset code, CODE_LEN*DIGIT_W bits; first-entered digit = most significant digit.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- key_valid  in  1  single-cycle strobe; key_digit valid.
- key_digit  in  DIGIT_W  digit value.
- clear  in  1  abort current entry.
- relock  in  1  end unlock window early.
- prog_req  in  1  enter programming mode (honoured only when unlocked).
- unlocked  out  1  actuator enable.
- locked_out  out  1  lockout active.
- prog_mode  out  1  programming in progress.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits captured in current entry.
- state  out  2  00 IDLE, 01 UNLOCK, 10 LOCKOUT, 11 PROG.

Behaviour:
- Reset (rst=0 at edge): state=IDLE; code register=DEFAULT_CODE; fail_cnt=0; digit_cnt=0; timer=0; mismatch flag=0; all flag outputs 0. Reset mid-entry or mid-lockout discards everything; a programmed code reverts to DEFAULT_CODE.
- All outputs are registered or decoded from registered state. unlocked=(state==UNLOCK), locked_out=(state==LOCKOUT), prog_mode=(state==PROG).
- IDLE:
  - Each key_valid compares key_digit with code digit[digit_cnt], ORs any miss into the mismatch flag, and increments digit_cnt.
  - On the CODE_LEN-th digit, evaluate including that digit:
    - Match: go to UNLOCK, fail_cnt=0, timer=UNLOCK_CYC-1.
    - Miss and fail_cnt+1==MAX_FAIL: go to LOCKOUT, fail_cnt=MAX_FAIL, timer=LOCKOUT_CYC-1.
    - Miss otherwise: stay in IDLE, fail_cnt+1.
  - In all three cases digit_cnt=0 and mismatch=0.
  - unlocked/locked_out rises the cycle after the edge that samples the final digit (latency 1).
- clear in IDLE: digit_cnt=0, mismatch=0, fail_cnt unchanged. If clear and key_valid occur in the same cycle, clear wins and the digit is dropped.
- UNLOCK:
  - Timer decrements each cycle; at timer==0 go to IDLE, so unlocked is high exactly UNLOCK_CYC cycles.
  - relock: go to IDLE next edge.
  - prog_req: go to PROG, digit_cnt=0.
  - If relock and prog_req occur together, relock wins.
  - key_valid and clear are ignored.
- LOCKOUT:
  - Held exactly LOCKOUT_CYC cycles, then IDLE with fail_cnt=0.
  - key_valid, clear, relock and prog_req are ignored.
- PROG:
  - Each key_valid shifts key_digit into a shadow register and increments digit_cnt.
  - On the CODE_LEN-th digit the code register is loaded atomically from the shadow plus the final digit; go to IDLE, digit_cnt=0.
  - clear aborts: go to IDLE, code unchanged, digit_cnt=0.
  - No timeout.
- fail_cnt saturates at MAX_FAIL and never wraps. digit_cnt never exceeds CODE_LEN-1 while observable.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
- Defaults; keys 1,2,3,4 on consecutive strobes → unlocked=1 from the cycle after digit 4 for exactly 8 cycles; fail_cnt=0; then state=IDLE.
- Keys 1,2,3,5 three times → fail_cnt 1, then 2, then locked_out=1 for 16 cycles. Keys strobed during lockout are ignored. Afterwards fail_cnt=0 and 1,2,3,4 unlocks.
- Keys 1,2, then clear together with key 9, then 1,2,3,4 → unlocks; fail_cnt stays 0; the digit 9 is dropped.
- Unlock, prog_req, keys 9,8,7,6 → prog_mode high during entry, then IDLE. 1,2,3,4 now fails (fail_cnt=1); 9,8,7,6 unlocks and clears fail_cnt.
- Unlock, prog_req, keys 5,5, clear → IDLE; code still 1234. Unlock then relock on cycle 3 → unlocked high 3 cycles.
- rst=0 mid-lockout and after reprogramming → state=IDLE, all outputs 0, code reverts to 1234.
